// File: rtl/issue_pair_queue.sv
// Dual-issue front-end queue: buffers fetched instructions and issues legal pairs or singles to decode.
// Optional performance counters are compiled in when ISSUE_PERF_EN is defined.
module issue_pair_queue #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  FetchValidF,
  input  logic [63:0] InstrF,
  input  logic [31:0] PCF,
  output logic        FetchReadyF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic [31:0] InstrD1,
  output logic [31:0] InstrD2,
  output logic [31:0] PCD1,
  output logic [31:0] PCD2,
  output logic        ValidD1,
  output logic        ValidD2
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0] PerfPairCnt,
  output logic [31:0] PerfSingleCnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [PW-1:0] head_nx;
  logic [31:0]   older;
  logic [31:0]   younger;
  logic          pair_ok;
  logic          do_issue;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;

  // Stores and branches carry immediate bits in the rd field, so they never write a register.
  function automatic logic writes_rd(input logic [31:0] ins);
    return (ins[6:0] != OP_STORE) && (ins[6:0] != OP_BRANCH);
  endfunction

  function automatic logic pair_legal(input logic [31:0] a, input logic [31:0] b);
    logic ok;
    logic a_wr;
    ok   = 1'b1;
    a_wr = writes_rd(a) && (a[11:7] != 5'd0);
    if ((a[6:0] == OP_BRANCH) || (a[6:0] == OP_JAL) || (a[6:0] == OP_JALR)) ok = 1'b0;
    if (a[6:0] == OP_LOAD) ok = 1'b0;
    if (b[6:0] == OP_STORE) ok = 1'b0;
    if (a_wr && ((b[19:15] == a[11:7]) || (b[24:20] == a[11:7]))) ok = 1'b0;
    if (a_wr && writes_rd(b) && (b[11:7] == a[11:7])) ok = 1'b0;
    return ok;
  endfunction

  assign FetchReadyF = (CW'(DEPTH) - count) >= CW'(2);

  // Issue and push decisions for this cycle.
  always_comb begin
    head_nx  = head + PW'(1);
    older    = instr_q[head];
    younger  = instr_q[head_nx];
    do_issue = !StallD && !FlushD;
    pair_ok  = (count >= CW'(2)) && pair_legal(older, younger);
    pop_n    = CW'(0);
    push_n   = CW'(0);
    if (do_issue && (count != CW'(0))) begin
      pop_n = pair_ok ? CW'(2) : CW'(1);
    end else begin
      pop_n = CW'(0);
    end
    if (FetchReadyF && FetchValidF[0] && !FlushD) begin
      push_n = FetchValidF[1] ? CW'(2) : CW'(1);
    end else begin
      push_n = CW'(0);
    end
  end

  // Queue storage writes at the tail.
  always_ff @(posedge clk) begin
    if (push_n != CW'(0)) begin
      instr_q[tail] <= InstrF[31:0];
      pc_q[tail]    <= PCF;
      if (push_n == CW'(2)) begin
        instr_q[tail + PW'(1)] <= InstrF[63:32];
        pc_q[tail + PW'(1)]    <= PCF + 32'd4;
      end
    end
  end

  // Pointers, occupancy and registered decode-slot outputs.
  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      InstrD1 <= NOP;
      InstrD2 <= NOP;
      PCD1    <= 32'd0;
      PCD2    <= 32'd0;
      ValidD1 <= 1'b0;
      ValidD2 <= 1'b0;
    end else begin
      tail  <= tail + PW'(push_n);
      head  <= head + PW'(pop_n);
      count <= count + push_n - pop_n;
      if (do_issue) begin
        InstrD1 <= (pop_n != CW'(0)) ? older : NOP;
        PCD1    <= (pop_n != CW'(0)) ? pc_q[head] : 32'd0;
        ValidD1 <= (pop_n != CW'(0));
        InstrD2 <= (pop_n == CW'(2)) ? younger : NOP;
        PCD2    <= (pop_n == CW'(2)) ? pc_q[head_nx] : 32'd0;
        ValidD2 <= (pop_n == CW'(2));
      end
    end
  end

`ifdef ISSUE_PERF_EN
  // Issue statistics; flush freezes them because do_issue is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      PerfPairCnt   <= 32'd0;
      PerfSingleCnt <= 32'd0;
    end else if (pop_n == CW'(2)) begin
      PerfPairCnt <= PerfPairCnt + 32'd1;
    end else if (pop_n == CW'(1)) begin
      PerfSingleCnt <= PerfSingleCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_pair_queue.sv
// Directed self-checking bench for issue_pair_queue (perf counters checked when ISSUE_PERF_EN is defined).
module tb_issue_pair_queue;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADD_1_23 = 32'h0031_00B3;  // add x1,x2,x3
  localparam logic [31:0] ADD_4_56 = 32'h0062_8233;  // add x4,x5,x6
  localparam logic [31:0] SUB_7_12 = 32'h4020_83B3;  // sub x7,x1,x2
  localparam logic [31:0] LW_5_1   = 32'h0000_A283;  // lw x5,0(x1)
  localparam logic [31:0] SW_2_3   = 32'h0021_A023;  // sw x2,0(x3)

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  FetchValidF;
  logic [63:0] InstrF;
  logic [31:0] PCF;
  logic        FetchReadyF;
  logic        StallD;
  logic        FlushD;
  logic [31:0] InstrD1, InstrD2, PCD1, PCD2;
  logic        ValidD1, ValidD2;
`ifdef ISSUE_PERF_EN
  logic [31:0] PerfPairCnt, PerfSingleCnt;
`endif

  int checks = 0;
  int errors = 0;

  issue_pair_queue dut (
    .clk(clk), .rst(rst), .FetchValidF(FetchValidF), .InstrF(InstrF), .PCF(PCF),
    .FetchReadyF(FetchReadyF), .StallD(StallD), .FlushD(FlushD),
    .InstrD1(InstrD1), .InstrD2(InstrD2), .PCD1(PCD1), .PCD2(PCD2),
    .ValidD1(ValidD1), .ValidD2(ValidD2)
`ifdef ISSUE_PERF_EN
    , .PerfPairCnt(PerfPairCnt), .PerfSingleCnt(PerfSingleCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc);
    FetchValidF = v;
    InstrF      = {b, a};
    PCF         = pc;
  endtask

  initial begin
    rst = 1'b1; StallD = 1'b0; FlushD = 1'b0;
    fetch(2'b00, 32'd0, 32'd0, 32'd0);
    step(); step();
    rst = 1'b0;
    chk("rst_instr1", InstrD1, NOP);
    chk("rst_instr2", InstrD2, NOP);
    chk("rst_pc1", PCD1, 32'd0);
    chk("rst_valid", {30'd0, ValidD1, ValidD2}, 32'd0);
    chk("rst_ready", {31'd0, FetchReadyF}, 32'd1);

    // independent pair
    fetch(2'b11, ADD_1_23, ADD_4_56, 32'h100); step();
    fetch(2'b00, 32'd0, 32'd0, 32'd0);
    chk("push_no_early_issue", {31'd0, ValidD1}, 32'd0);
    step();
    chk("pair_i1", InstrD1, ADD_1_23);
    chk("pair_i2", InstrD2, ADD_4_56);
    chk("pair_pc1", PCD1, 32'h100);
    chk("pair_pc2", PCD2, 32'h104);
    chk("pair_valid", {30'd0, ValidD1, ValidD2}, 32'd3);
    step();
    chk("empty_valid", {30'd0, ValidD1, ValidD2}, 32'd0);

    // RAW hazard splits the pair
    fetch(2'b11, ADD_1_23, SUB_7_12, 32'h200); step();
    fetch(2'b00, 32'd0, 32'd0, 32'd0); step();
    chk("raw_a_i1", InstrD1, ADD_1_23);
    chk("raw_a_i2", InstrD2, NOP);
    chk("raw_a_valid", {30'd0, ValidD1, ValidD2}, 32'd2);
    step();
    chk("raw_b_i1", InstrD1, SUB_7_12);
    chk("raw_b_pc1", PCD1, 32'h204);
    chk("raw_b_valid", {30'd0, ValidD1, ValidD2}, 32'd2);

    // load in slot-1 is illegal; store then load pairs
    fetch(2'b11, LW_5_1, SW_2_3, 32'h300); step();
    fetch(2'b00, 32'd0, 32'd0, 32'd0); step();
    chk("lw_alone_i1", InstrD1, LW_5_1);
    chk("lw_alone_v2", {31'd0, ValidD2}, 32'd0);
    step();
    chk("sw_alone_i1", InstrD1, SW_2_3);
    chk("sw_alone_pc1", PCD1, 32'h304);
    fetch(2'b11, SW_2_3, LW_5_1, 32'h400); step();
    fetch(2'b00, 32'd0, 32'd0, 32'd0); step();
    chk("swlw_i1", InstrD1, SW_2_3);
    chk("swlw_i2", InstrD2, LW_5_1);
    chk("swlw_valid", {30'd0, ValidD1, ValidD2}, 32'd3);

    // fill under stall: count 0->2->4->6->8
    StallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch(2'b11, ADD_1_23, ADD_4_56, 32'h500 + 32'(8 * i));
      step();
      chk("fill_ready", {31'd0, FetchReadyF}, (i < 3) ? 32'd1 : 32'd0);
      chk("stall_hold_i1", InstrD1, SW_2_3);
    end
    fetch(2'b11, ADD_1_23, ADD_4_56, 32'h600); step();
    chk("full_ready", {31'd0, FetchReadyF}, 32'd0);
    chk("stall_hold_pc1", PCD1, 32'h400);
    fetch(2'b00, 32'd0, 32'd0, 32'd0);
    StallD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_pc1", PCD1, 32'h500 + 32'(8 * i));
      chk("drain_pc2", PCD2, 32'h504 + 32'(8 * i));
    end
    step();
    chk("drain_done", {30'd0, ValidD1, ValidD2}, 32'd0);
    chk("drain_ready", {31'd0, FetchReadyF}, 32'd1);

`ifdef ISSUE_PERF_EN
    chk("perf_pairs", PerfPairCnt, 32'd6);
    chk("perf_singles", PerfSingleCnt, 32'd4);
`endif

    // flush with count=5 and a concurrent push
    StallD = 1'b1;
    fetch(2'b11, ADD_1_23, ADD_4_56, 32'h700); step();
    fetch(2'b11, ADD_1_23, ADD_4_56, 32'h708); step();
    fetch(2'b01, ADD_1_23, ADD_4_56, 32'h710); step();
    FlushD = 1'b1;
    fetch(2'b11, ADD_1_23, ADD_4_56, 32'h800); step();
    FlushD = 1'b0; StallD = 1'b0;
    fetch(2'b00, 32'd0, 32'd0, 32'd0);
    chk("flush_valid", {30'd0, ValidD1, ValidD2}, 32'd0);
    chk("flush_i1", InstrD1, NOP);
    chk("flush_ready", {31'd0, FetchReadyF}, 32'd1);
    step();
    chk("flush_empty", {30'd0, ValidD1, ValidD2}, 32'd0);
    chk("flush_pc1", PCD1, 32'd0);

    // 2'b10 is ignored
    fetch(2'b10, ADD_1_23, ADD_4_56, 32'h900); step();
    fetch(2'b00, 32'd0, 32'd0, 32'd0); step();
    chk("illegal_fv", {30'd0, ValidD1, ValidD2}, 32'd0);

    // reset mid-operation
    fetch(2'b11, ADD_1_23, ADD_4_56, 32'hA00); step();
    fetch(2'b00, 32'd0, 32'd0, 32'd0);
    rst = 1'b1; step();
    rst = 1'b0; step();
    chk("midrst_valid", {30'd0, ValidD1, ValidD2}, 32'd0);
    chk("midrst_i1", InstrD1, NOP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
